// File: rtl/bk_pipe_addsub.sv
// ---------------------------------------------------------------------------
// bk_pipe_addsub
//   Pipelined adder/subtractor. The carry network is a Brent-Kung parallel
//   prefix: the up-sweep is evaluated in front of the stage-1 register and the
//   down-sweep, sum XOR and flags are evaluated behind it. An optional output
//   register stage follows. Every stage has a valid bit and a ready/valid
//   handshake on both sides. A stage advances when it is empty or when the
//   stage downstream of it advances.
//
// Parameters
//   WIDTH   : operand width (8, 16, 32 or 64)
//   REG_OUT : 1 = registered output stage (latency 2), 0 = none (latency 1)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand beat valid
//   in_ready  out  a beat is accepted this cycle (combinational from out_ready)
//   a, b      in   operands, WIDTH bits
//   cin       in   carry-in, only used for op=2'b10
//   op        in   00 add, 01 a-b, 10 add with cin, 11 treated as add
//   out_valid out  result beat valid
//   out_ready in   downstream accepts the result
//   sum       out  result, WIDTH bits
//   cout      out  carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   ovf       out  two's-complement signed overflow
//   zero      out  sum is all zeros
// ---------------------------------------------------------------------------
module bk_pipe_addsub #(
  parameter int WIDTH   = 32,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LG = $clog2(WIDTH);

  // -------------------------------------------------------------------------
  // Operand conditioning: subtract is a + ~b + 1.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    case (op)
      2'b01: begin
        b_eff   = ~b;
        cin_eff = 1'b1;
      end
      2'b10: cin_eff = cin;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Up-sweep. Level 0 holds bitwise generate/propagate. At level gl, every
  // position whose index+1 is a multiple of 2^gl merges the block 2^(gl-1)
  // below it; all other positions pass through unchanged. After the last
  // level, positions 2^k-1 hold the full prefix [i:0].
  // -------------------------------------------------------------------------
  genvar gl, gi;

  for (gl = 0; gl <= LG; gl++) begin : g_up
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
    if (gl == 0) begin : g_bitwise
      assign grp_g = a & b_eff;
      assign grp_p = a ^ b_eff;
    end else begin : g_level
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (((gi + 1) % (1 << gl)) == 0) begin : g_merge
          assign grp_g[gi] = g_up[gl-1].grp_g[gi]
                           | (g_up[gl-1].grp_p[gi] & g_up[gl-1].grp_g[gi - (1 << (gl - 1))]);
          assign grp_p[gi] = g_up[gl-1].grp_p[gi] & g_up[gl-1].grp_p[gi - (1 << (gl - 1))];
        end else begin : g_pass
          assign grp_g[gi] = g_up[gl-1].grp_g[gi];
          assign grp_p[gi] = g_up[gl-1].grp_p[gi];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 registers
  // -------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;     // bitwise propagate, needed for the sum XOR
  logic [WIDTH-1:0] s1_g_q, s1_g_d;     // up-sweep group generate
  logic [WIDTH-1:0] s1_gp_q, s1_gp_d;   // up-sweep group propagate
  logic             s1_cin_q, s1_cin_d;
  logic             s1_sa_q, s1_sa_d;
  logic             s1_sb_q, s1_sb_d;
  logic             s1_adv;
  logic             s1_load;

  assign s1_p_d   = g_up[0].grp_p;
  assign s1_g_d   = g_up[LG].grp_g;
  assign s1_gp_d  = g_up[LG].grp_p;
  assign s1_cin_d = cin_eff;
  assign s1_sa_d  = a[WIDTH-1];
  assign s1_sb_d  = b_eff[WIDTH-1];

  assign in_ready   = s1_adv;
  assign s1_load    = s1_adv & in_valid;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_gp_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_p_q   <= s1_p_d;
        s1_g_q   <= s1_g_d;
        s1_gp_q  <= s1_gp_d;
        s1_cin_q <= s1_cin_d;
        s1_sa_q  <= s1_sa_d;
        s1_sb_q  <= s1_sb_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Down-sweep. Level LG is the registered up-sweep result. Going down, at
  // level gl the positions with (i+1) mod 2^(gl+1) == 2^gl (above the first
  // block) combine with the full prefix ending 2^gl below them. Level 0 then
  // holds the full prefix [i:0] at every position.
  // -------------------------------------------------------------------------
  for (gl = 0; gl <= LG; gl++) begin : g_dn
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
    if (gl == LG) begin : g_top
      assign grp_g = s1_g_q;
      assign grp_p = s1_gp_q;
    end else begin : g_level
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if ((((gi + 1) % (1 << (gl + 1))) == (1 << gl)) && ((gi + 1) > (1 << (gl + 1)))) begin : g_merge
          assign grp_g[gi] = g_dn[gl+1].grp_g[gi]
                           | (g_dn[gl+1].grp_p[gi] & g_dn[gl+1].grp_g[gi - (1 << gl)]);
          assign grp_p[gi] = g_dn[gl+1].grp_p[gi] & g_dn[gl+1].grp_p[gi - (1 << gl)];
        end else begin : g_pass
          assign grp_g[gi] = g_dn[gl+1].grp_g[gi];
          assign grp_p[gi] = g_dn[gl+1].grp_p[gi];
        end
      end
    end
  end

  // Carry into bit i+1 folds the external carry-in through the prefix [i:0].
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c, ovf_c, zero_c;

  assign carry  = {g_dn[0].grp_g | (g_dn[0].grp_p & {WIDTH{s1_cin_q}}), s1_cin_q};
  assign sum_c  = s1_p_q ^ carry[WIDTH-1:0];
  assign cout_c = carry[WIDTH];
  assign ovf_c  = (s1_sa_q == s1_sb_q) & (sum_c[WIDTH-1] != s1_sa_q);
  assign zero_c = ~|sum_c;

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  if (REG_OUT != 0) begin : g_oreg
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;
    logic             s2_adv;
    logic             s2_load;

    assign s2_adv      = ~out_valid_q | out_ready;
    assign s2_load     = s2_adv & s1_valid_q;
    assign s1_adv      = ~s1_valid_q | s2_adv;
    assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        sum_q       <= '0;
        cout_q      <= 1'b0;
        ovf_q       <= 1'b0;
        zero_q      <= 1'b0;
      end else begin
        out_valid_q <= out_valid_d;
        if (s2_load) begin
          sum_q  <= sum_c;
          cout_q <= cout_c;
          ovf_q  <= ovf_c;
          zero_q <= zero_c;
        end
      end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
  end else begin : g_ocomb
    assign s1_adv    = ~s1_valid_q | out_ready;
    assign out_valid = s1_valid_q;
    assign sum       = sum_c;
    assign cout      = cout_c;
    assign ovf       = ovf_c;
    // Cleared stage-1 registers evaluate to a zero sum; keep the flag low
    // while nothing valid is presented.
    assign zero      = zero_c & s1_valid_q;
  end

endmodule
